// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: runs multi-cycle word loads/stores
// against an external asynchronous SRAM and stalls the pipeline until
// each access finishes. Load data is registered on readDataSRAM_mem.
//
// Handshake: a request is "valid" while memRead_mem or memWrite_mem is
// high, and it is accepted on the edge where the FSM is in IDLE and the
// address is word-aligned. memStall stays high from that cycle through the
// whole ACCESS phase and drops in DONE, which is the single cycle in which
// the pipeline advances and MEM_WB captures the result. Request inputs seen
// in DONE still belong to the finished op and are ignored.
module mem_sram_ctrl #(
   parameter int ADDR_W      = 11,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead_mem,
   input  logic              memWrite_mem,
   input  logic [31:0]       aluResult_mem,
   input  logic [31:0]       writeData_mem,
   output logic [31:0]       readDataSRAM_mem,
   output logic              memStall,
   output logic              alignErr,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dout,
   input  logic [31:0]       sram_din,
   output logic              sram_drive,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [1:0]        dbgState
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       opWrite;
   logic       req;
   logic       aligned;
   logic       unusedAddrBits;

   assign req     = memRead_mem | memWrite_mem;
   assign aligned = (aluResult_mem[1:0] == 2'b00);

   // Address bits above the SRAM size are dropped, so accesses wrap.
   assign unusedAddrBits = ^aluResult_mem[31:ADDR_W+2];

   // Stall must rise in the same cycle the request is presented so the
   // pipeline never advances past an accepted access.
   assign memStall = (state == ACCESS) | ((state == IDLE) & req & aligned);

   assign dbgState = state;

   // Access FSM; every SRAM strobe and bus output is a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= 4'd0;
         opWrite          <= 1'b0;
         readDataSRAM_mem <= 32'd0;
         sram_addr        <= '0;
         sram_dout        <= 32'd0;
         sram_drive       <= 1'b0;
         sram_ce_n        <= 1'b1;
         sram_oe_n        <= 1'b1;
         sram_we_n        <= 1'b1;
         alignErr         <= 1'b0;
      end else begin
         alignErr <= 1'b0;
         case (state)
            IDLE: begin
               if (req && aligned) begin
                  // A simultaneous read and write request is a write.
                  sram_addr  <= aluResult_mem[ADDR_W+1:2];
                  sram_dout  <= writeData_mem;
                  opWrite    <= memWrite_mem;
                  cnt        <= 4'(WAIT_CYCLES - 1);
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= memWrite_mem;
                  sram_we_n  <= ~memWrite_mem;
                  sram_drive <= memWrite_mem;
                  state      <= ACCESS;
               end else if (req) begin
                  alignErr <= 1'b1;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  if (!opWrite) begin
                     readDataSRAM_mem <= sram_din;
                  end
                  sram_ce_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
                  sram_we_n  <= 1'b1;
                  sram_drive <= 1'b0;
                  state      <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with WAIT_CYCLES=2, ADDR_W=11.
// Cycle 0 of an access is the IDLE cycle where the request is presented;
// cycles 1-2 are ACCESS, cycle 3 is DONE.
module tb_mem_sram_ctrl;

   logic        clk;
   logic        reset;
   logic        memRead_mem;
   logic        memWrite_mem;
   logic [31:0] aluResult_mem;
   logic [31:0] writeData_mem;
   logic [31:0] readDataSRAM_mem;
   logic        memStall;
   logic        alignErr;
   logic [10:0] sram_addr;
   logic [31:0] sram_dout;
   logic [31:0] sram_din;
   logic        sram_drive;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [1:0]  dbgState;

   int n_cmp;
   int n_err;

   // Control bundle: {memStall, ce_n, oe_n, we_n, drive}
   logic [4:0] ctl;
   assign ctl = {memStall, sram_ce_n, sram_oe_n, sram_we_n, sram_drive};

   localparam logic [4:0] CTL_IDLE  = 5'b01110;
   localparam logic [4:0] CTL_REQ   = 5'b11110;
   localparam logic [4:0] CTL_RD    = 5'b10010;
   localparam logic [4:0] CTL_WR    = 5'b10101;

   mem_sram_ctrl #(.ADDR_W(11), .WAIT_CYCLES(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .memRead_mem      (memRead_mem),
      .memWrite_mem     (memWrite_mem),
      .aluResult_mem    (aluResult_mem),
      .writeData_mem    (writeData_mem),
      .readDataSRAM_mem (readDataSRAM_mem),
      .memStall         (memStall),
      .alignErr         (alignErr),
      .sram_addr        (sram_addr),
      .sram_dout        (sram_dout),
      .sram_din         (sram_din),
      .sram_drive       (sram_drive),
      .sram_ce_n        (sram_ce_n),
      .sram_oe_n        (sram_oe_n),
      .sram_we_n        (sram_we_n),
      .dbgState         (dbgState)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_cmp++;
      if (ctl !== CTL_IDLE) begin
         n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_IDLE);
      end
      n_cmp++;
      if (readDataSRAM_mem !== 32'd0) begin
         n_err++; $display("FAIL reset_rdata: got %h want 0", readDataSRAM_mem);
      end
      n_cmp++;
      if (sram_addr !== 11'd0 || sram_dout !== 32'd0 || alignErr !== 1'b0) begin
         n_err++; $display("FAIL reset_bus: got addr %h dout %h aerr %b want 0 0 0",
                           sram_addr, sram_dout, alignErr);
      end
      reset = 1'b0;
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         step();
         n_cmp++;
         if (ctl !== CTL_IDLE || readDataSRAM_mem !== 32'd0) begin
            n_err++; $display("FAIL idle_c%0d: got ctl %b rdata %h want %b 0",
                              c, ctl, readDataSRAM_mem, CTL_IDLE);
         end
      end
   endtask

   task automatic test_read();
      memRead_mem = 1'b1; aluResult_mem = 32'h0000_0010; sram_din = 32'hDEAD_BEEF;
      #1;
      for (int c = 0; c < 4; c++) begin
         logic [4:0] exp_ctl;
         if (c > 0) step();
         exp_ctl = (c == 0) ? CTL_REQ : (c < 3) ? CTL_RD : CTL_IDLE;
         n_cmp++;
         if (ctl !== exp_ctl) begin
            n_err++; $display("FAIL read_ctl_c%0d: got %b want %b", c, ctl, exp_ctl);
         end
         if (c == 1 || c == 2) begin
            n_cmp++;
            if (sram_addr !== 11'd4) begin
               n_err++; $display("FAIL read_addr_c%0d: got %h want 4", c, sram_addr);
            end
         end
         if (c == 3) begin
            n_cmp++;
            if (readDataSRAM_mem !== 32'hDEAD_BEEF) begin
               n_err++; $display("FAIL read_data: got %h want deadbeef", readDataSRAM_mem);
            end
         end
      end
      memRead_mem = 1'b0;
      step();
   endtask

   task automatic test_write();
      memWrite_mem = 1'b1; aluResult_mem = 32'h0000_0020; writeData_mem = 32'h1234_5678;
      sram_din = 32'h5555_5555;
      #1;
      for (int c = 0; c < 4; c++) begin
         logic [4:0] exp_ctl;
         if (c > 0) step();
         exp_ctl = (c == 0) ? CTL_REQ : (c < 3) ? CTL_WR : CTL_IDLE;
         n_cmp++;
         if (ctl !== exp_ctl) begin
            n_err++; $display("FAIL write_ctl_c%0d: got %b want %b", c, ctl, exp_ctl);
         end
         if (c == 1 || c == 2) begin
            n_cmp++;
            if (sram_addr !== 11'd8 || sram_dout !== 32'h1234_5678) begin
               n_err++; $display("FAIL write_bus_c%0d: got addr %h dout %h want 8 12345678",
                                 c, sram_addr, sram_dout);
            end
         end
         n_cmp++;
         if (readDataSRAM_mem !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL write_rdata_c%0d: got %h want deadbeef", c, readDataSRAM_mem);
         end
      end
      memWrite_mem = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      memRead_mem = 1'b1; aluResult_mem = 32'h0000_0044; sram_din = 32'hCAFE_F00D;
      #1;
      for (int c = 0; c < 8; c++) begin
         logic [4:0] exp_ctl;
         if (c > 0) step();
         case (c)
            0, 4:    exp_ctl = CTL_REQ;
            1, 2:    exp_ctl = CTL_RD;
            5, 6:    exp_ctl = CTL_WR;
            default: exp_ctl = CTL_IDLE;
         endcase
         if (c == 4) #1;
         n_cmp++;
         if (ctl !== exp_ctl) begin
            n_err++; $display("FAIL b2b_ctl_c%0d: got %b want %b", c, ctl, exp_ctl);
         end
         if (c == 1) begin
            n_cmp++;
            if (sram_addr !== 11'h011) begin
               n_err++; $display("FAIL b2b_raddr: got %h want 011", sram_addr);
            end
         end
         if (c == 5) begin
            n_cmp++;
            if (sram_addr !== 11'h012 || sram_dout !== 32'hA5A5_A5A5) begin
               n_err++; $display("FAIL b2b_wbus: got addr %h dout %h want 012 a5a5a5a5",
                                 sram_addr, sram_dout);
            end
         end
         if (c >= 3) begin
            n_cmp++;
            if (readDataSRAM_mem !== 32'hCAFE_F00D) begin
               n_err++; $display("FAIL b2b_rdata_c%0d: got %h want cafef00d", c, readDataSRAM_mem);
            end
         end
         // Pipeline advances at the end of DONE: present the next op.
         if (c == 3) begin
            memRead_mem = 1'b0; memWrite_mem = 1'b1;
            aluResult_mem = 32'h0000_0048; writeData_mem = 32'hA5A5_A5A5;
            sram_din = 32'h0;
         end
      end
      memWrite_mem = 1'b0;
      step();
   endtask

   task automatic test_misaligned();
      memRead_mem = 1'b1; aluResult_mem = 32'h0000_0013;
      #1;
      n_cmp++;
      if (ctl !== CTL_IDLE || alignErr !== 1'b0) begin
         n_err++; $display("FAIL mis_c0: got ctl %b aerr %b want %b 0", ctl, alignErr, CTL_IDLE);
      end
      step();
      memRead_mem = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== CTL_IDLE || alignErr !== 1'b1) begin
         n_err++; $display("FAIL mis_c1: got ctl %b aerr %b want %b 1", ctl, alignErr, CTL_IDLE);
      end
      step();
      n_cmp++;
      if (ctl !== CTL_IDLE || alignErr !== 1'b0) begin
         n_err++; $display("FAIL mis_c2: got ctl %b aerr %b want %b 0", ctl, alignErr, CTL_IDLE);
      end
   endtask

   task automatic test_both();
      memRead_mem = 1'b1; memWrite_mem = 1'b1;
      aluResult_mem = 32'h0000_0030; writeData_mem = 32'h0BAD_CAFE; sram_din = 32'h7777_7777;
      #1;
      step();
      n_cmp++;
      if (ctl !== CTL_WR || sram_addr !== 11'h00C || sram_dout !== 32'h0BAD_CAFE) begin
         n_err++; $display("FAIL both_access: got ctl %b addr %h dout %h want %b 00c 0badcafe",
                           ctl, sram_addr, sram_dout, CTL_WR);
      end
      step();
      step();
      n_cmp++;
      if (ctl !== CTL_IDLE || readDataSRAM_mem !== 32'hCAFE_F00D) begin
         n_err++; $display("FAIL both_done: got ctl %b rdata %h want %b cafef00d",
                           ctl, readDataSRAM_mem, CTL_IDLE);
      end
      memRead_mem = 1'b0; memWrite_mem = 1'b0;
      step();
   endtask

   // 0x2004 >> 2 = 0x801; top bit beyond 11 address bits is dropped -> 0x001.
   task automatic test_wrap();
      memRead_mem = 1'b1; aluResult_mem = 32'h0000_2004; sram_din = 32'h1111_2222;
      #1;
      step();
      n_cmp++;
      if (ctl !== CTL_RD || sram_addr !== 11'h001) begin
         n_err++; $display("FAIL wrap_access: got ctl %b addr %h want %b 001", ctl, sram_addr, CTL_RD);
      end
      step();
      step();
      n_cmp++;
      if (ctl !== CTL_IDLE || readDataSRAM_mem !== 32'h1111_2222) begin
         n_err++; $display("FAIL wrap_done: got ctl %b rdata %h want %b 11112222",
                           ctl, readDataSRAM_mem, CTL_IDLE);
      end
      memRead_mem = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      memWrite_mem = 1'b1; aluResult_mem = 32'h0000_0040; writeData_mem = 32'hFFFF_0000;
      #1;
      step();
      n_cmp++;
      if (ctl !== CTL_WR) begin
         n_err++; $display("FAIL rmid_access: got %b want %b", ctl, CTL_WR);
      end
      reset = 1'b1; memWrite_mem = 1'b0;
      step();
      n_cmp++;
      if (ctl !== CTL_IDLE || readDataSRAM_mem !== 32'd0) begin
         n_err++; $display("FAIL rmid_after: got ctl %b rdata %h want %b 0",
                           ctl, readDataSRAM_mem, CTL_IDLE);
      end
      reset = 1'b0;
      step();
      step();
      n_cmp++;
      if (ctl !== CTL_IDLE) begin
         n_err++; $display("FAIL rmid_settle: got %b want %b", ctl, CTL_IDLE);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; memRead_mem = 1'b0; memWrite_mem = 1'b0;
      aluResult_mem = 32'd0; writeData_mem = 32'd0; sram_din = 32'd0;
      test_reset();
      test_idle();
      test_read();
      test_write();
      test_back_to_back();
      test_misaligned();
      test_both();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- MEM-stage data-memory controller for the 5-stage MIPS pipeline.
- Accepts load and store requests from EX/MEM and runs multi-cycle word accesses to the external SRAM.
- Stalls the pipeline until each access completes, then presents load data on readDataSRAM_mem for MEM_WB to capture.
- It is the producing end of the readDataSRAM path.

Parameters:
ADDR_W, 11, SRAM word-address width (SRAM holds 2^ADDR_W 32-bit words)
WAIT_CYCLES, 2, SRAM access cycles with strobes asserted; legal range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
memRead_mem  input  1  load request from EX/MEM
memWrite_mem  input  1  store request from EX/MEM
aluResult_mem  input  32  byte address of the access
writeData_mem  input  32  store data
readDataSRAM_mem  output  32  registered load data, to MEM_WB
memStall  output  1  freeze PC/IF_ID/ID_EX/EX_MEM and hold MEM_WB input
alignErr  output  1  one-cycle pulse: misaligned request dropped
sram_addr  output  ADDR_W  SRAM word address
sram_dout  output  32  write data to SRAM
sram_din  input  32  read data from SRAM
sram_drive  output  1  1 = controller drives SRAM data bus
sram_ce_n  output  1  chip enable, active low
sram_oe_n  output  1  output enable, active low
sram_we_n  output  1  write enable, active low

Behaviour:
- Reset state: FSM in IDLE; readDataSRAM_mem=0; sram_addr=0; sram_dout=0; sram_drive=0; sram_ce_n/oe_n/we_n=1; alignErr=0; memStall=0.
- Reset mid-access: next edge enters IDLE and deasserts strobes; a pending write is abandoned; readData is cleared.
- Request: req = memRead_mem | memWrite_mem. If both are high, the access is a write.
- Address mapping:
  - sram_addr = aluResult_mem[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses wrap modulo SRAM size.
  - Misaligned means aluResult_mem[1:0] != 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - memStall = req & aligned (combinational).
  - On the edge with req & aligned:
    - latch address, writeData and op;
    - load cnt = WAIT_CYCLES-1;
    - go to ACCESS.
  - On the edge with req & misaligned:
    - alignErr=1 for the next cycle only;
    - no strobes, no stall, stay in IDLE.
- ACCESS:
  - memStall=1; sram_ce_n=0.
  - Read: sram_oe_n=0, sram_we_n=1, sram_drive=0.
  - Write: sram_we_n=0, sram_oe_n=1, sram_drive=1; sram_dout holds the latched data.
  - sram_addr and sram_dout are stable for all of ACCESS.
  - cnt decrements each cycle.
  - At cnt==0:
    - read: capture sram_din into readDataSRAM_mem;
    - go to DONE.
- DONE:
  - memStall=0; all strobes deasserted; sram_drive=0.
  - The pipeline advances at the end of this cycle, and MEM_WB captures readDataSRAM_mem.
  - Request inputs are ignored in DONE because they still belong to the completed op.
  - Next state is always IDLE.
- Latency:
  - The access occupies the MEM stage for WAIT_CYCLES+2 cycles.
  - memStall is high for WAIT_CYCLES+1 of them.
- Strobe timing: all SRAM outputs and strobes are registered (decoded from state registers). None are combinational from inputs.
- Data hold: readDataSRAM_mem holds its value until the next completed read. Writes do not change it.
- Bus safety: sram_drive=1 only in ACCESS for a write, never together with sram_oe_n=0.
- Back-to-back: one IDLE cycle always separates accesses; there is no request pipelining.

Test Plan:
- Idle: req=0 for 10 cycles -> memStall=0, ce_n/oe_n/we_n=1, readData=0.
- Read, WAIT=2, addr 0x0000_0010, sram_din=0xDEADBEEF:
  - memStall high cycles 0-2;
  - oe_n/ce_n low cycles 1-2, sram_addr=4;
  - cycle 3: memStall=0, readDataSRAM_mem=0xDEADBEEF.
- Write addr 0x0000_0020, data 0x12345678:
  - we_n low cycles 1-2, sram_addr=8, sram_dout=0x12345678, sram_drive=1;
  - oe_n stays 1;
  - readData unchanged.
- Read immediately followed by write: second access starts in the cycle after DONE; prior readData is held through the write.
- Misaligned read at 0x0000_0013 -> alignErr pulses one cycle, no strobes, memStall=0; memRead+memWrite together at an aligned address -> write performed.
- Reset asserted in the first ACCESS cycle of a write -> next cycle IDLE, we_n=1, sram_drive=0, readData=0, memStall=0.
